// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences the shared 16-bit big-endian instruction/data memory
// and arbitrates it between the fetch and data (load/store) requesters.
// Every memory control/address signal is registered, so the combinational
// memory sees one stable access cycle. Each transaction takes 3 cycles:
// IDLE (accept), ACCESS (bus driven), RESP (valid pulse).
//
// Optional build macro: MEM_ARB_FAIR_EN adds a fetch wait counter. After
// STARVE_LIMIT waiting IDLE cycles, fetch wins the next simultaneous
// arbitration. Without the macro, data always has priority.
//
// Ports:
//   clk, rest                      clock (rising edge), async active-low reset
//   if_req/if_addr                 fetch request, held until accepted
//   if_ready                       fetch grant (combinational, IDLE only)
//   if_valid/if_data/if_fault      fetch response
//   d_req/d_we/d_addr/d_wdata      data request, held until accepted
//   d_ready                        data grant (combinational, IDLE only)
//   d_valid/d_rdata/d_fault        data response (loads and stores)
//   Mem_Address/Mem_Read/Mem_Write/Write_Data   registered memory bus
//   Mem_Result                     memory read result
module mem_arbiter #(
  parameter int unsigned INSTR_TOP    = 1023,
  parameter int unsigned MEM_TOP      = 4095,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ready,
  output logic        if_valid,
  output logic [15:0] if_data,
  output logic        if_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic        d_fault,
  output logic [15:0] Mem_Address,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic [15:0] Write_Data,
  input  logic [15:0] Mem_Result
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned XW = AW + 1;
  localparam int unsigned CW = 4;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = data requester owns the access
  logic          fault_q, fault_d;
  logic [AW-1:0] mem_address_d;
  logic          mem_read_d, mem_write_d;
  logic [DW-1:0] write_data_d;
  logic          if_valid_d, if_fault_d, d_valid_d, d_fault_d;
  logic [DW-1:0] if_data_d, d_rdata_d;

  logic          if_addr_bad, d_addr_bad;
  logic          grant_if, grant_d;
  logic          fetch_first;

  // 17-bit range checks so 0xFFFF+1 cannot wrap into a legal address
  assign if_addr_bad = (XW'(if_addr) + XW'(1)) > XW'(INSTR_TOP);
  assign d_addr_bad  = (XW'(d_addr) < XW'(INSTR_TOP + 1)) ||
                       ((XW'(d_addr) + XW'(1)) > XW'(MEM_TOP));

`ifdef MEM_ARB_FAIR_EN
  logic [CW-1:0] wait_q, wait_d;

  assign fetch_first = wait_q >= CW'(STARVE_LIMIT);

  // Count IDLE cycles in which fetch waits; saturate, clear on fetch grant
  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE) begin
      if (grant_if) begin
        wait_d = '0;
      end else if (if_req && (wait_q != '1)) begin
        wait_d = wait_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign fetch_first = 1'b0;
`endif

  // Grants exist only in IDLE; data wins unless fetch has been starved
  assign grant_d  = (state_q == IDLE) && d_req && !(fetch_first && if_req);
  assign grant_if = (state_q == IDLE) && if_req && !grant_d;
  assign d_ready  = grant_d;
  assign if_ready = grant_if;

  // Next-state and next-output logic; the bus defaults to idle every cycle
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    fault_d       = fault_q;
    mem_address_d = '0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    write_data_d  = '0;
    if_valid_d    = 1'b0;
    d_valid_d     = 1'b0;
    if_data_d     = if_data;
    if_fault_d    = if_fault;
    d_rdata_d     = d_rdata;
    d_fault_d     = d_fault;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          owner_d = 1'b1;
          fault_d = d_addr_bad;
          state_d = ACCESS;
          if (!d_addr_bad) begin
            mem_address_d = d_addr;
            mem_read_d    = !d_we;
            mem_write_d   = d_we;
            write_data_d  = d_we ? d_wdata : '0;
          end
        end else if (grant_if) begin
          owner_d = 1'b0;
          fault_d = if_addr_bad;
          state_d = ACCESS;
          if (!if_addr_bad) begin
            mem_address_d = if_addr;
          end
        end
      end

      ACCESS: begin
        state_d = RESP;
        if (owner_q) begin
          d_valid_d = 1'b1;
          d_fault_d = fault_q;
          // Registered Mem_Write marks a store in flight: no read data
          d_rdata_d = (fault_q || Mem_Write) ? '0 : Mem_Result;
        end else begin
          if_valid_d = 1'b1;
          if_fault_d = fault_q;
          if_data_d  = fault_q ? '0 : Mem_Result;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      fault_q     <= 1'b0;
      Mem_Address <= '0;
      Mem_Read    <= 1'b0;
      Mem_Write   <= 1'b0;
      Write_Data  <= '0;
      if_valid    <= 1'b0;
      if_data     <= '0;
      if_fault    <= 1'b0;
      d_valid     <= 1'b0;
      d_rdata     <= '0;
      d_fault     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      fault_q     <= fault_d;
      Mem_Address <= mem_address_d;
      Mem_Read    <= mem_read_d;
      Mem_Write   <= mem_write_d;
      Write_Data  <= write_data_d;
      if_valid    <= if_valid_d;
      if_data     <= if_data_d;
      if_fault    <= if_fault_d;
      d_valid     <= d_valid_d;
      d_rdata     <= d_rdata_d;
      d_fault     <= d_fault_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: byte-array memory model, table of transactions
// with expected responses pushed to per-port queues at grant time and popped
// when the DUT pulses valid, plus hand sequences for arbitration and reset.
module tb_mem_arbiter;

  logic        clk;
  logic        rest;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ready;
  logic        if_valid;
  logic [15:0] if_data;
  logic        if_fault;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ready;
  logic        d_valid;
  logic [15:0] d_rdata;
  logic        d_fault;
  logic [15:0] Mem_Address;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [15:0] Write_Data;
  logic [15:0] Mem_Result;

  mem_arbiter dut (
    .clk        (clk),
    .rest       (rest),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ready   (if_ready),
    .if_valid   (if_valid),
    .if_data    (if_data),
    .if_fault   (if_fault),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ready    (d_ready),
    .d_valid    (d_valid),
    .d_rdata    (d_rdata),
    .d_fault    (d_fault),
    .Mem_Address(Mem_Address),
    .Mem_Read   (Mem_Read),
    .Mem_Write  (Mem_Write),
    .Write_Data (Write_Data),
    .Mem_Result (Mem_Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational big-endian memory, written at the clock edge
  logic [7:0]  mem [0:4095];
  logic [11:0] a0, a1;
  assign a0 = Mem_Address[11:0];
  assign a1 = 12'(Mem_Address + 16'd1);
  assign Mem_Result = {mem[a0], mem[a1]};

  always @(posedge clk) begin
    if (Mem_Write === 1'b1) begin
      mem[a0] <= Write_Data[15:8];
      mem[a1] <= Write_Data[7:0];
    end
  end

  int checks = 0;
  int errors = 0;
  int wr_cycles = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fault;
    logic [15:0] data;
    string       name;
  } resp_t;

  resp_t if_q[$];
  resp_t d_q[$];

  // Response monitor: pop expectation on every valid pulse
  always @(negedge clk) begin
    if (rest === 1'b1 && Mem_Write === 1'b1) wr_cycles++;
    if (if_valid === 1'b1) begin
      if (if_q.size() == 0) begin
        chk("spurious if_valid", if_valid, 0);
      end else begin
        resp_t r;
        r = if_q.pop_front();
        chk({r.name, " if_fault"}, if_fault, r.fault);
        chk({r.name, " if_data"}, if_data, r.data);
      end
    end
    if (d_valid === 1'b1) begin
      if (d_q.size() == 0) begin
        chk("spurious d_valid", d_valid, 0);
      end else begin
        resp_t r;
        r = d_q.pop_front();
        chk({r.name, " d_fault"}, d_fault, r.fault);
        chk({r.name, " d_rdata"}, d_rdata, r.data);
      end
    end
  end

  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          exp_fault;
    logic [15:0] exp_data;
    string       name;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic push_exp(input bit is_d, input bit fault, input logic [15:0] data, input string name);
    resp_t r;
    r.fault = fault;
    r.data  = data;
    r.name  = name;
    if (is_d) d_q.push_back(r);
    else      if_q.push_back(r);
  endtask

  // One transaction: grant, bus contents at N+1, valid pulse at N+2 only
  task automatic issue(input vec_t v, output int waits);
    bit granted;
    logic [15:0] e_addr, e_wd;
    logic e_rd, e_wr;
    granted = 1'b0;
    waits = 0;
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    for (int k = 0; k < 16; k++) begin
      if ((v.is_d ? d_ready : if_ready) === 1'b1) begin
        granted = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
      #1;
    end
    chk({v.name, " grant"}, granted, 1);
    if (!granted) begin
      d_req = 1'b0; if_req = 1'b0;
      return;
    end
    push_exp(v.is_d, v.exp_fault, v.exp_data, v.name);
    @(posedge clk);
    #1;
    d_req = 1'b0; if_req = 1'b0;

    e_addr = 16'h0; e_wd = 16'h0; e_rd = 1'b0; e_wr = 1'b0;
    if (!v.exp_fault) begin
      e_addr = v.addr;
      if (v.is_d) begin
        e_rd = !v.we;
        e_wr = v.we;
        if (v.we) e_wd = v.wdata;
      end
    end
    @(negedge clk);
    chk({v.name, " access bus"}, {Mem_Address, Write_Data, Mem_Read, Mem_Write},
        {e_addr, e_wd, e_rd, e_wr});
    @(negedge clk);
    chk({v.name, " valid at N+2"}, {if_valid, d_valid}, {!v.is_d, v.is_d});
    chk({v.name, " bus idle at N+2"}, {Mem_Address, Write_Data, Mem_Read, Mem_Write}, 34'h0);
    @(negedge clk);
    chk({v.name, " valid low at N+3"}, {if_valid, d_valid}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, dg;
    bit got;
    vec_t v;

    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);

    vecs[0]  = '{0, 0, 16'h0010, 16'h0000, 0, 16'h1011, "fetch 0010"};
    vecs[1]  = '{0, 0, 16'h03FE, 16'h0000, 0, 16'hFEFF, "fetch 03FE"};
    vecs[2]  = '{0, 0, 16'h03FF, 16'h0000, 1, 16'h0000, "fetch 03FF"};
    vecs[3]  = '{0, 0, 16'hFFFF, 16'h0000, 1, 16'h0000, "fetch FFFF"};
    vecs[4]  = '{1, 1, 16'h0400, 16'hBEEF, 0, 16'h0000, "store 0400"};
    vecs[5]  = '{1, 0, 16'h0400, 16'h0000, 0, 16'hBEEF, "load 0400"};
    vecs[6]  = '{1, 1, 16'h0402, 16'h1234, 0, 16'h0000, "store 0402"};
    vecs[7]  = '{1, 0, 16'h0402, 16'h0000, 0, 16'h1234, "load 0402"};
    vecs[8]  = '{1, 1, 16'h0100, 16'hDEAD, 1, 16'h0000, "store 0100"};
    vecs[9]  = '{1, 1, 16'h03FF, 16'hDEAD, 1, 16'h0000, "store 03FF"};
    vecs[10] = '{1, 0, 16'h0FFE, 16'h0000, 0, 16'hFEFF, "load 0FFE"};
    vecs[11] = '{1, 0, 16'h0FFF, 16'h0000, 1, 16'h0000, "load 0FFF"};
    vecs[12] = '{1, 0, 16'hFFFF, 16'h0000, 1, 16'h0000, "load FFFF"};
    vecs[13] = '{1, 0, 16'h03FE, 16'h0000, 1, 16'h0000, "load 03FE"};
    vecs[14] = '{1, 1, 16'h0FFE, 16'hA5A5, 0, 16'h0000, "store 0FFE"};
    vecs[15] = '{1, 0, 16'h0FFE, 16'h0000, 0, 16'hA5A5, "reload 0FFE"};
    vecs[16] = '{0, 0, 16'h0100, 16'h0000, 0, 16'h0001, "fetch 0100"};

    rest = 1'b0;
    if_req = 1'b0; if_addr = 16'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
    #22;
    chk("reset if outputs", {if_ready, if_valid, if_data, if_fault}, 19'h0);
    chk("reset d outputs", {d_ready, d_valid, d_rdata, d_fault}, 19'h0);
    chk("reset bus", {Mem_Address, Write_Data, Mem_Read, Mem_Write}, 34'h0);
    @(negedge clk);
    rest = 1'b1;

    for (int i = 0; i < NV; i++) issue(vecs[i], w);

    // Simultaneous requests: data first, fetch granted 3 cycles later
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500;
    #1;
    chk("sim d_ready", d_ready, 1);
    chk("sim if_ready", if_ready, 0);
    push_exp(1, 0, 16'h0001, "sim load 0500");
    @(posedge clk);
    #1;
    d_req = 1'b0;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      n++;
      if (if_ready === 1'b1) break;
    end
    chk("sim fetch wait cycles", n, 3);
    push_exp(0, 0, 16'h1011, "sim fetch 0010");
    @(posedge clk);
    #1;
    if_req = 1'b0;
    repeat (4) @(negedge clk);

`ifdef MEM_ARB_FAIR_EN
    // Data held continuously: fetch wins after STARVE_LIMIT waiting cycles
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500;
    #1;
    dg = 0; got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (if_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (d_ready === 1'b1) begin
        dg++;
        push_exp(1, 0, 16'h0001, "fair load 0500");
      end
      @(negedge clk);
      #1;
    end
    chk("fair fetch granted", got, 1);
    chk("fair data grants first", dg, 4);
    push_exp(0, 0, 16'h0001, "fair fetch 0100");
    @(posedge clk);
    #1;
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);
`endif

    // Reset during the ACCESS cycle of a store aborts it silently
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0600; d_wdata = 16'hCAFE;
    #1;
    chk("abort store grant", d_ready, 1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    chk("abort Mem_Write in access", Mem_Write, 1);
    #2;
    rest = 1'b0;
    #1;
    chk("abort Mem_Write async drop", Mem_Write, 0);
    chk("abort bus cleared", {Mem_Address, Write_Data}, 32'h0);
    repeat (2) @(negedge clk);
    rest = 1'b1;
    chk("post reset d outputs", {d_valid, d_rdata, d_fault}, 18'h0);
    repeat (3) @(negedge clk);
    v = '{1, 0, 16'h0600, 16'h0000, 0, 16'h0001, "load 0600 after abort"};
    issue(v, w);
    chk("idle after reset, immediate grant", w, 0);

    repeat (3) @(negedge clk);
    chk("if queue drained", if_q.size(), 0);
    chk("d queue drained", d_q.size(), 0);
    chk("Mem_Write cycles", wr_cycles, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the shared 16-bit big-endian instruction/data memory and arbitrates it between the instruction-fetch requester and the data (load/store) requester.
- Registers every memory control and address signal, so the combinational memory sees stable inputs for exactly one access cycle.
- Latches the memory Result and returns it with a one-cycle valid pulse.
- Range-checks addresses and raises faults instead of issuing illegal accesses.

Parameters:
- INSTR_TOP, 1023, last legal instruction byte address (instruction region is 0..INSTR_TOP).
- MEM_TOP, 4095, last memory byte address; a 16-bit access needs addr+1 <= MEM_TOP.
- STARVE_LIMIT, 4, fetch wait-cycle limit, used only with MEM_ARB_FAIR_EN; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rest  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until accepted
- if_addr  in  16  fetch byte address
- if_ready  out  1  fetch grant; acceptance = if_req & if_ready
- if_valid  out  1  one-cycle pulse: if_data/if_fault valid
- if_data  out  16  fetched word
- if_fault  out  1  fetch address out of range
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until accepted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  16  data byte address
- d_wdata  in  16  store data
- d_ready  out  1  data grant
- d_valid  out  1  one-cycle completion pulse, for loads and for stores
- d_rdata  out  16  load data; 0 for stores and faults
- d_fault  out  1  data address out of range
- Mem_Address  out  16  to memory
- Mem_Read  out  1  to memory
- Mem_Write  out  1  to memory
- Write_Data  out  16  to memory
- Mem_Result  in  16  memory Result

Behaviour:
- Reset (rest=0, asynchronous): state=IDLE; all outputs 0, including Mem_Write. A store in progress is aborted with no completion pulse; the requester re-issues it.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - if_ready/d_ready are combinational and high only for the selected requester.
  - Default selection is fixed priority, data over fetch.
  - On acceptance, register the bus values for the selected access, then go to ACCESS:
    - Fetch: Mem_Read=0, Mem_Write=0, Mem_Address=if_addr.
    - Load: Mem_Read=1, Mem_Address=d_addr.
    - Store: Mem_Write=1, Mem_Address=d_addr, Write_Data=d_wdata.
  - The accepted owner is also registered.
- ACCESS:
  - The bus is stable for exactly one cycle.
  - At the clock edge, capture Mem_Result into the owner's data register (loads and fetches only).
  - Return the bus to idle (address 0, Mem_Read=0, Mem_Write=0, Write_Data=0), then go to RESP.
- RESP:
  - Pulse the owner's valid output for 1 cycle; the non-owner's outputs do not change.
  - Go to IDLE; no grant is issued in RESP.
- Latency: acceptance at cycle N, bus driven N+1, valid at N+2. The next acceptance is no earlier than N+3, so there is one access per 3 cycles.
- Fault checks, evaluated at acceptance:
  - Fetch faults if if_addr+1 > INSTR_TOP.
  - Data faults if d_addr < INSTR_TOP+1 or d_addr+1 > MEM_TOP. Stores never write the instruction region.
  - On a fault, no memory access is issued (bus stays idle during ACCESS), and the owner receives valid=1, fault=1, data=0 in RESP.
- Fault computation is 17-bit, so 0xFFFF+1 does not wrap to a legal address.
- Simultaneous requests: the data request wins; fetch remains pending and sees if_ready=0.
- Requests dropped before acceptance are ignored. Outputs (data, fault) hold their values until the next response for that port.

Optional Feature:
- MEM_ARB_FAIR_EN defined:
  - A 4-bit wait counter increments each IDLE cycle in which if_req=1 and fetch is not granted.
  - When the counter reaches STARVE_LIMIT, fetch wins the next simultaneous arbitration.
  - The counter clears on fetch acceptance and on reset.
- Not defined: pure data priority; no counter logic is present.

Test Plan:
- Fetch only, if_addr=0x0010, memory bytes [0x10]=0x10, [0x11]=0x11 -> Mem_Read=0/Mem_Write=0 at N+1, if_valid at N+2 with if_data=0x1011, if_fault=0.
- Store d_addr=0x0400, d_wdata=0xBEEF, then load 0x0400 -> Mem_Write high exactly 1 cycle; load returns d_rdata=0xBEEF, d_valid at N+2.
- if_req and d_req (load 0x0500) both high at the same cycle -> data granted first, fetch granted at N+3; with MEM_ARB_FAIR_EN and d_req held continuously, fetch is granted after 4 waiting IDLE cycles.
- Fault cases: fetch 0x03FF, store 0x0100, load 0x0FFF, load 0xFFFF -> fault=1, data=0, valid pulse; Mem_Write never asserted.
- Assert rest=0 during ACCESS of a store to 0x0600 -> Mem_Write drops immediately (asynchronously); no d_valid; state is IDLE after release.
